// File: rtl/bus_gate_keeper.sv
// bus_gate_keeper: priority-gated bus mux with keeper, contention flag/counter and last-driver debug register
module bus_gate_keeper #(
  parameter int WIDTH = 16,
  parameter int NUM_SRC = 4,
  parameter int CNT_W = 8,
  localparam int SRC_W = $clog2(NUM_SRC)
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_SRC-1:0]       Gate,
  input  logic [NUM_SRC*WIDTH-1:0] Din,
  input  logic                     Clr_Err,
  output logic [WIDTH-1:0]         Out_Bus,
  output logic                     Bus_Valid,
  output logic                     Contention,
  output logic                     Contention_Err,
  output logic [CNT_W-1:0]         Contention_Cnt,
  output logic [SRC_W-1:0]         Last_Src
);
  logic [WIDTH-1:0] hold_q, drv;
  logic [SRC_W-1:0] win, last_q;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_SRC; i++) if (Gate[i]) win = SRC_W'(i);
  end
  assign drv = Din[win*WIDTH +: WIDTH];
  assign Bus_Valid = |Gate;
  // more than one bit set iff clearing the lowest set bit leaves something
  assign Contention = |(Gate & (Gate - NUM_SRC'(1)));
  assign Out_Bus = Bus_Valid ? drv : hold_q;
  always_comb begin
    err_d = Contention | (err_q & ~Clr_Err);
    cnt_d = Clr_Err ? CNT_W'(Contention) : Contention ? (&cnt_q ? cnt_q : cnt_q + CNT_W'(1)) : cnt_q;
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hold_q <= '0;
      last_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (Bus_Valid) begin
        hold_q <= drv;
        last_q <= win;
      end
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  assign Contention_Err = err_q;
  assign Contention_Cnt = cnt_q;
  assign Last_Src = last_q;
endmodule

// File: doc/bus_gate_keeper.md
Name: bus_gate_keeper

Overview:
- Parametrised successor to the datapath bus gate mux: selects one of NUM_SRC WIDTH-bit sources onto the shared CPU bus from one-hot gate signals issued by the ISDU.
- Adds a bus keeper: with no gate active, the bus holds the last driven value instead of floating.
- Adds contention detection with a priority-resolved output, a sticky error flag, a saturating error counter, and a registered last-driver index for debug.
- Sits between the datapath source registers/units (PC, MDR, ALU, MARMUX, ...) and all bus consumers.

Parameters:
- WIDTH, 16, bus width in bits.
- NUM_SRC, 4, number of gated sources; legal range is NUM_SRC >= 2.
- CNT_W, 8, width of the contention counter.
- SRC_W, $clog2(NUM_SRC), index width; derived, not overridden.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Gate  input  NUM_SRC  one-hot gate enables; bit i gates source i.
- Din  input  NUM_SRC*WIDTH  flattened sources; source i = Din[i*WIDTH +: WIDTH].
- Clr_Err  input  1  synchronous clear of Contention_Err and Contention_Cnt.
- Out_Bus  output  WIDTH  bus value.
- Bus_Valid  output  1  combinational; high when at least one Gate bit is set.
- Contention  output  1  combinational; high when two or more Gate bits are set.
- Contention_Err  output  1  sticky registered error flag.
- Contention_Cnt  output  CNT_W  saturating count of contention cycles.
- Last_Src  output  SRC_W  registered index of the most recent winning source.

Behaviour:
- Clock and reset: single clock Clk. Reset is asynchronous, active-high.
- Reset values: Hold_Q = 0, Contention_Err = 0, Contention_Cnt = 0, Last_Src = 0.
- Winner selection: combinational. Winner = highest set index of Gate (bit NUM_SRC-1 has highest priority). Drv = Din slice of the winner.
- Out_Bus: combinational, zero latency.
  - If Bus_Valid, Out_Bus = Drv.
  - Otherwise Out_Bus = Hold_Q.
  - Out_Bus never carries Z or X, for any legal input.
- Keeper register Hold_Q:
  - On each rising edge with Bus_Valid = 1: Hold_Q <= Drv and Last_Src <= winner index.
  - When Bus_Valid = 0: both hold.
- Contention: popcount(Gate) > 1. Out_Bus still carries the priority winner, and Hold_Q and Last_Src update normally.
- Contention_Err, on each edge:
  - Set if Contention.
  - Else cleared if Clr_Err.
  - Else hold.
  - If Contention and Clr_Err occur in the same cycle, set wins (result = 1).
- Contention_Cnt, on each edge:
  - Clr_Err and Contention together: cnt <= 1.
  - Clr_Err alone: cnt <= 0.
  - Contention alone: cnt <= cnt + 1, saturating at 2^CNT_W - 1 (no wrap).
  - Neither: hold.
- Reset mid-operation: all registers clear immediately, without waiting for a clock edge. If no gate is active, Out_Bus goes to 0 immediately. While Reset is high, Out_Bus with an active gate still passes Drv combinationally.
- Data change while gated: Out_Bus tracks Din combinationally. Hold_Q captures the value present at the edge.
- No internal FSM beyond these registers; implementation must be fully synthesizable with no tristates.

Test Plan:
- Reset, then Gate=0000 -> Out_Bus=0x0000, Bus_Valid=0, Last_Src=0, Contention_Err=0.
- Din sources {3:0x3000, 2:0xBEEF, 1:0x1234, 0:0x00FF}. Gate=0100 for one cycle, then 0000 -> Out_Bus=0xBEEF during and after, Last_Src=2. Change Din[2] to 0x0000 while Gate=0000 -> Out_Bus stays 0xBEEF.
- Gate=1001 for 3 cycles -> Out_Bus=0x3000, Contention=1, Contention_Err=1 after first edge, Contention_Cnt=3, Last_Src=3.
- Contention held for 300 cycles (CNT_W=8) -> Contention_Cnt saturates at 255. Then Clr_Err alone for one cycle -> Cnt=0, Err=0. Clr_Err with Gate=0011 -> Cnt=1, Err=1.
- Assert Reset asynchronously between edges, with Gate=0000 and Hold_Q=0x1234 -> Out_Bus=0x0000 before next edge, all counters/flags 0.
- Random one-hot sweep with NUM_SRC=8, WIDTH=32 -> Out_Bus matches the selected source every cycle, Contention never asserts, Contention_Cnt stays 0.
